// File: rtl/spike_mac_accum.sv
// ---------------------------------------------------------------------------
// spike_mac_accum
//
// Pipelined spike-gated multiply-accumulate. Each beat carries N spike bits and
// N signed weights. Every weight is masked by its spike bit. The masked weights
// are reduced into a partial sum, and BEATS consecutive partial sums are then
// accumulated into one saturating result per frame.
//
// Pipeline: S1 input register -> S2 partial-sum register -> accumulator/result.
// A beat accepted at edge k shows up in the result at edge k+2.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   clear      in   synchronous flush of the in-flight frame (result is kept)
//   in_valid   in   beat present
//   in_ready   out  beat can be accepted (combinational from out_ready/clear)
//   pixels_in  in   N spike bits, lane i = pixels_in[i]
//   weights_in in   N*W weights, lane i = weights_in[i*W +: W]
//   out_valid  out  frame result held
//   out_ready  in   downstream accepts the result
//   sum_out    out  signed frame sum, ACC_W bits
//   sat_out    out  frame saturated at least once
// ---------------------------------------------------------------------------
module spike_mac_accum #(
    parameter int N     = 5,
    parameter int W     = 16,
    parameter int BEATS = 4,
    parameter int ACC_W = 24
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N-1:0]            pixels_in,
    input  logic [N*W-1:0]          weights_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] sum_out,
    output logic                    sat_out
);

    localparam int PW = W + $clog2(N);
    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0]    LAST_CNT = CW'(BEATS - 1);
    localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

    if (N < 2 || BEATS < 1 || ACC_W < PW) begin : g_bad_param
        $error("spike_mac_accum: need N>=2, BEATS>=1, ACC_W>=W+clog2(N)");
    end

    // ---------------- state ----------------
    logic              s1_valid_q, s1_valid_d;
    logic              s1_last_q,  s1_last_d;
    logic [N-1:0]      s1_pix_q,   s1_pix_d;
    logic [N*W-1:0]    s1_w_q,     s1_w_d;
    logic [CW-1:0]     beat_cnt_q, beat_cnt_d;

    logic              s2_valid_q, s2_valid_d;
    logic              s2_last_q,  s2_last_d;
    logic [PW-1:0]     psum_q,     psum_d;

    logic [ACC_W-1:0]  acc_q,      acc_d;
    logic              sat_q,      sat_d;

    logic              out_valid_q, out_valid_d;
    logic [ACC_W-1:0]  sum_out_q,   sum_out_d;
    logic              sat_out_q,   sat_out_d;

    // ---------------- handshake ----------------
    logic stall;
    logic accept;
    logic load;

    // A last beat waiting in S2 cannot retire while the previous result is
    // still unclaimed; everything upstream of the output then freezes.
    assign stall    = s2_valid_q && s2_last_q && out_valid_q && !out_ready;
    assign in_ready = rst_n && !stall && !clear;
    assign accept   = in_valid && in_ready;
    assign load     = !clear && !stall && s2_valid_q && s2_last_q;

    // ---------------- S2 partial sum ----------------
    logic [PW-1:0] lane_val [N];
    logic [PW-1:0] psum_comb;

    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        assign lane_val[gi] = s1_pix_q[gi]
            ? {{(PW-W){s1_w_q[gi*W + W-1]}}, s1_w_q[gi*W +: W]}
            : '0;
    end

    // PW is wide enough that this reduction never overflows.
    always_comb begin
        psum_comb = '0;
        for (int i = 0; i < N; i++) begin
            psum_comb = psum_comb + lane_val[i];
        end
    end

    // ---------------- accumulate with saturation ----------------
    // acc_q and sat_q are already zero at the start of every frame (after a
    // last beat, clear or reset), so the first beat needs no special case.
    logic [ACC_W:0]   acc_ext;
    logic [ACC_W:0]   psum_ext;
    logic [ACC_W:0]   acc_sum;
    logic             ovf_pos;
    logic             ovf_neg;
    logic [ACC_W-1:0] acc_clamped;
    logic             sat_new;

    assign acc_ext  = {acc_q[ACC_W-1], acc_q};
    assign psum_ext = {{(ACC_W+1-PW){psum_q[PW-1]}}, psum_q};
    assign acc_sum  = acc_ext + psum_ext;

    // Sign bit and the bit below it disagree only when the sum left the
    // ACC_W-bit range; which one is set tells the direction.
    assign ovf_pos     = !acc_sum[ACC_W] &&  acc_sum[ACC_W-1];
    assign ovf_neg     =  acc_sum[ACC_W] && !acc_sum[ACC_W-1];
    assign acc_clamped = ovf_pos ? ACC_MAX : (ovf_neg ? ACC_MIN : acc_sum[ACC_W-1:0]);
    assign sat_new     = sat_q || ovf_pos || ovf_neg;

    // ---------------- next state ----------------
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_last_d   = s1_last_q;
        s1_pix_d    = s1_pix_q;
        s1_w_d      = s1_w_q;
        beat_cnt_d  = beat_cnt_q;
        s2_valid_d  = s2_valid_q;
        s2_last_d   = s2_last_q;
        psum_d      = psum_q;
        acc_d       = acc_q;
        sat_d       = sat_q;
        out_valid_d = out_valid_q;
        sum_out_d   = sum_out_q;
        sat_out_d   = sat_out_q;

        if (clear) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
            acc_d      = '0;
            sat_d      = 1'b0;
            beat_cnt_d = '0;
        end else if (!stall) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_pix_d   = pixels_in;
                s1_w_d     = weights_in;
                s1_last_d  = (beat_cnt_q == LAST_CNT);
                beat_cnt_d = (beat_cnt_q == LAST_CNT) ? '0 : beat_cnt_q + CW'(1);
            end

            s2_valid_d = s1_valid_q;
            s2_last_d  = s1_last_q;
            psum_d     = psum_comb;

            if (s2_valid_q) begin
                if (s2_last_q) begin
                    acc_d = '0;
                    sat_d = 1'b0;
                end else begin
                    acc_d = acc_clamped;
                    sat_d = sat_new;
                end
            end
        end

        // A fresh result wins over the consumption of the old one.
        if (load) begin
            out_valid_d = 1'b1;
            sum_out_d   = acc_clamped;
            sat_out_d   = sat_new;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_pix_q    <= '0;
            s1_w_q      <= '0;
            beat_cnt_q  <= '0;
            s2_valid_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            psum_q      <= '0;
            acc_q       <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
            sum_out_q   <= '0;
            sat_out_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s1_pix_q    <= s1_pix_d;
            s1_w_q      <= s1_w_d;
            beat_cnt_q  <= beat_cnt_d;
            s2_valid_q  <= s2_valid_d;
            s2_last_q   <= s2_last_d;
            psum_q      <= psum_d;
            acc_q       <= acc_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
            sum_out_q   <= sum_out_d;
            sat_out_q   <= sat_out_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum_out   = sum_out_q;
    assign sat_out   = sat_out_q;

endmodule

// File: tb/tb_spike_mac_accum.sv
// ---------------------------------------------------------------------------
// tb_spike_mac_accum
//
// Three instances share one stimulus stream:
//   u0: BEATS=4, ACC_W=24 (defaults)
//   u1: BEATS=4, ACC_W=20 (reaches saturation)
//   u2: BEATS=1, ACC_W=24 (one result per beat, back-pressure)
// Each instance has a frame-level reference model: accepted beats are summed
// with plain integer arithmetic, clamped per beat, and completed frames are
// queued and compared against every output handshake. Directed sequences add
// cycle-exact checks for latency, stall, clear and reset behaviour.
// ---------------------------------------------------------------------------
module tb_spike_mac_accum;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic        out_ready;
    logic [4:0]  pixels_in;
    logic [79:0] weights_in;

    logic   in_ready_w  [3];
    logic   out_valid_w [3];
    logic   sat_w       [3];
    longint sum_w       [3];
    int     res_cnt     [3] = '{0, 0, 0};

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- DUTs + reference models ----------------
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int     BEATS_G = (gi == 2) ? 1 : 4;
        localparam int     ACCW_G  = (gi == 1) ? 20 : 24;
        localparam longint HI      = (longint'(1) <<< (ACCW_G - 1)) - 1;
        localparam longint LO      = -(longint'(1) <<< (ACCW_G - 1));

        logic                     in_ready_s;
        logic                     out_valid_s;
        logic                     sat_s;
        logic signed [ACCW_G-1:0] sum_s;

        spike_mac_accum #(
            .N(5), .W(16), .BEATS(BEATS_G), .ACC_W(ACCW_G)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .clear     (clear),
            .in_valid  (in_valid),
            .in_ready  (in_ready_s),
            .pixels_in (pixels_in),
            .weights_in(weights_in),
            .out_valid (out_valid_s),
            .out_ready (out_ready),
            .sum_out   (sum_s),
            .sat_out   (sat_s)
        );

        assign in_ready_w[gi]  = in_ready_s;
        assign out_valid_w[gi] = out_valid_s;
        assign sat_w[gi]       = sat_s;
        assign sum_w[gi]       = longint'(sum_s);

        longint m_acc = 0;
        logic   m_sat = 1'b0;
        int     m_cnt = 0;
        longint q_sum [$];
        logic   q_sat [$];

        // Inputs change just after posedge, so at negedge everything that
        // decides the next edge's handshakes is settled.
        always @(negedge clk) begin : model
            longint psum;
            logic signed [15:0] wv;
            if (!rst_n) begin
                m_acc = 0; m_sat = 1'b0; m_cnt = 0;
                q_sum.delete(); q_sat.delete();
            end else begin
                if (out_valid_s && out_ready) begin
                    if (q_sum.size() == 0) begin
                        check($sformatf("u%0d_unexpected_result", gi), 1, 0);
                    end else begin
                        check($sformatf("u%0d_sum", gi), longint'(sum_s), q_sum.pop_front());
                        check($sformatf("u%0d_sat", gi), longint'(sat_s), longint'(q_sat.pop_front()));
                        res_cnt[gi]++;
                    end
                end
                if (clear) begin
                    m_acc = 0; m_sat = 1'b0; m_cnt = 0;
                end else if (in_valid && in_ready_s) begin
                    psum = 0;
                    for (int i = 0; i < 5; i++) begin
                        wv = weights_in[i*16 +: 16];
                        if (pixels_in[i]) psum += longint'(wv);
                    end
                    m_acc += psum;
                    if (m_acc > HI) begin m_acc = HI; m_sat = 1'b1; end
                    if (m_acc < LO) begin m_acc = LO; m_sat = 1'b1; end
                    m_cnt++;
                    if (m_cnt == BEATS_G) begin
                        q_sum.push_back(m_acc);
                        q_sat.push_back(m_sat);
                        m_acc = 0; m_sat = 1'b0; m_cnt = 0;
                    end
                end
            end
        end
    end

    // ---------------- helpers ----------------
    function automatic logic [79:0] pack5(input int w0, input int w1, input int w2,
                                          input int w3, input int w4);
        logic [79:0] v;
        v[15:0]  = w0[15:0];
        v[31:16] = w1[15:0];
        v[47:32] = w2[15:0];
        v[63:48] = w3[15:0];
        v[79:64] = w4[15:0];
        return v;
    endfunction

    // Called just after a posedge; returns just after the edge where u0
    // accepted the beat.
    task automatic drive_beat(input logic [4:0] pix, input logic [79:0] wts);
        int waited = 0;
        in_valid   = 1'b1;
        pixels_in  = pix;
        weights_in = wts;
        forever begin
            @(negedge clk);
            if (in_ready_w[0]) break;
            waited++;
            if (waited >= 50) begin
                check("accept_timeout", 0, 1);
                break;
            end
            @(posedge clk); #1;
            if (waited >= 3) out_ready = 1'b1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Returns at the negedge where instance g shows out_valid.
    task automatic wait_out(input int g);
        int n = 0;
        @(negedge clk);
        while (!out_valid_w[g] && n < 40) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("u%0d_result_timeout", g), longint'(out_valid_w[g]), 1);
    endtask

    function automatic logic [79:0] rand_w();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[79:0];
    endfunction

    // ---------------- stimulus ----------------
    logic [79:0] wts;
    int          r0;
    int          drops;
    int          pulse_t [$];
    int          exp_bp  [3] = '{7, 11, 13};

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        pixels_in = '0; weights_in = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_in_ready", longint'(in_ready_w[0]), 0);
        check("rst_out_valid", longint'(out_valid_w[0]), 0);
        check("rst_sum", sum_w[0], 0);
        check("rst_sat", longint'(sat_w[0]), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready", longint'(in_ready_w[0]), 1);
        @(posedge clk); #1;

        // Basic frame: 15 per beat, 4 beats, exact latency and 1-cycle pulse
        wts = pack5(1, 2, 3, 4, 5);
        repeat (4) drive_beat(5'b11111, wts);
        @(negedge clk); check("t1_ov_k", longint'(out_valid_w[0]), 0);
        @(negedge clk); check("t1_ov_k1", longint'(out_valid_w[0]), 0);
        @(negedge clk); check("t1_ov_k2", longint'(out_valid_w[0]), 1);
        check("t1_sum", sum_w[0], 60);
        check("t1_sat", longint'(sat_w[0]), 0);
        @(negedge clk); check("t1_ov_k3", longint'(out_valid_w[0]), 0);
        @(posedge clk); #1;

        // Signed masking
        wts = pack5(100, -200, 300, -400, 500);
        drive_beat(5'b10101, wts);
        drive_beat(5'b01010, wts);
        drive_beat(5'b00000, wts);
        drive_beat(5'b11111, wts);
        wait_out(0);
        check("t2_sum", sum_w[0], 600);
        check("t2_sat", longint'(sat_w[0]), 0);
        @(posedge clk); #1;

        // Saturation on the 20-bit accumulator
        wts = pack5(32767, 32767, 32767, 32767, 32767);
        repeat (4) drive_beat(5'b11111, wts);
        wait_out(1);
        check("t3_sat_sum", sum_w[1], 524287);
        check("t3_sat_flag", longint'(sat_w[1]), 1);
        check("t3_wide_sum", sum_w[0], 655340);
        check("t3_wide_sat", longint'(sat_w[0]), 0);
        @(posedge clk); #1;
        repeat (4) drive_beat(5'b00000, rand_w());
        wait_out(1);
        check("t3_zero_sum", sum_w[1], 0);
        check("t3_zero_sat", longint'(sat_w[1]), 0);
        repeat (4) @(posedge clk);
        #1;

        // Back-pressure on the BEATS=1 instance
        out_ready = 1'b0;
        drive_beat(5'b00001, pack5(7, 0, 0, 0, 0));
        drive_beat(5'b00001, pack5(11, 0, 0, 0, 0));
        drive_beat(5'b00001, pack5(13, 0, 0, 0, 0));
        repeat (3) @(negedge clk);
        check("t4_held_valid", longint'(out_valid_w[2]), 1);
        check("t4_held_sum", sum_w[2], 7);
        check("t4_in_ready_low", longint'(in_ready_w[2]), 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check($sformatf("t4_valid_%0d", j), longint'(out_valid_w[2]), 1);
            check($sformatf("t4_order_%0d", j), sum_w[2], longint'(exp_bp[j]));
        end
        @(negedge clk);
        check("t4_no_dup", longint'(out_valid_w[2]), 0);
        @(posedge clk); #1;

        // clear and reset mid-frame
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        r0 = res_cnt[0];
        wts = pack5(1, 2, 3, 4, 5);
        repeat (2) drive_beat(5'b11111, wts);
        repeat (3) @(posedge clk);
        #1;
        clear = 1'b1; in_valid = 1'b1; pixels_in = 5'b11111; weights_in = wts;
        @(negedge clk);
        check("t5_clear_in_ready", longint'(in_ready_w[0]), 0);
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
        drive_beat(5'b11111, wts);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("t5_rst_in_ready", longint'(in_ready_w[0]), 0);
        check("t5_rst_out_valid", longint'(out_valid_w[0]), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) drive_beat(5'b11111, wts);
        wait_out(0);
        check("t5_sum", sum_w[0], 60);
        @(negedge clk);
        check("t5_result_count", longint'(res_cnt[0] - r0), 1);
        @(posedge clk); #1;

        // Streaming: 3 frames back-to-back
        drops = 0;
        fork
            begin
                for (int f = 0; f < 3; f++) begin
                    logic [79:0] fw;
                    logic [4:0]  fp;
                    fw = rand_w();
                    fp = 5'($urandom());
                    repeat (4) drive_beat(fp, fw);
                end
            end
            begin
                for (int c = 0; c < 30; c++) begin
                    @(negedge clk);
                    if (in_valid && !in_ready_w[0]) drops++;
                    if (out_valid_w[0]) pulse_t.push_back(c);
                end
            end
        join
        check("t6_in_ready_drops", longint'(drops), 0);
        check("t6_pulses", longint'(pulse_t.size()), 3);
        if (pulse_t.size() == 3) begin
            check("t6_gap1", longint'(pulse_t[1] - pulse_t[0]), 4);
            check("t6_gap2", longint'(pulse_t[2] - pulse_t[1]), 4);
        end
        @(posedge clk); #1;

        // Randomized traffic with random back-pressure
        for (int b = 0; b < 80; b++) begin
            int idle;
            out_ready = ($urandom_range(0, 3) != 0);
            idle = $urandom_range(0, 2);
            repeat (idle) begin
                @(posedge clk); #1;
            end
            drive_beat(5'($urandom()), rand_w());
        end
        out_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("u0_queue_empty", longint'(g_dut[0].q_sum.size()), 0);
        check("u1_queue_empty", longint'(g_dut[1].q_sum.size()), 0);
        check("u2_queue_empty", longint'(g_dut[2].q_sum.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
